// File: rtl/alu_share_arb.sv
// -----------------------------------------------------------------------------
// alu_share_arb
//   Shares one external combinational ALU between NREQ requesters. Requesters
//   are picked round-robin. Each operation goes through three states:
//   accept (IDLE) -> execute (EXEC) -> respond (RESP). The operands and the
//   result are both registered, so the ALU sits between two flop stages.
//   The op code is not decoded; it goes to the ALU unchanged.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   OPW   ALU op-code width
//
// Ports
//   clk        in   1         rising-edge clock
//   rst        in   1         asynchronous, active-high reset
//   req_valid  in   NREQ      requester i has an operation pending
//   req_ready  out  NREQ      one-hot accept, driven only in IDLE
//   req_a      in   NREQ*32   operand A, requester i at [32*i +: 32]
//   req_b      in   NREQ*32   operand B, same packing
//   req_op     in   NREQ*OPW  op code, requester i at [OPW*i +: OPW]
//   rsp_valid  out  NREQ      one-hot: result ready for the granted requester
//   rsp_ready  in   NREQ      requester i consumes its result
//   rsp_res    out  32        result; holds its value after the handshake
//   alu_a      out  32        to ALU src_a (registered operand)
//   alu_b      out  32        to ALU src_b (registered operand)
//   alu_op     out  OPW       to ALU op (registered)
//   alu_res    in   32        from ALU result
// -----------------------------------------------------------------------------
module alu_share_arb #(
    parameter int NREQ = 2,
    parameter int OPW  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ*OPW-1:0]  req_op,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [31:0]          rsp_res,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [OPW-1:0]       alu_op,
    input  logic [31:0]          alu_res
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic [IDXW-1:0]   last_q;     // most recently granted requester
    logic [IDXW-1:0]   gnt_q;      // requester owning the in-flight operation
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [OPW-1:0]    op_q;
    logic [31:0]       res_q;

    logic [IDXW-1:0]   gnt_d;
    logic              any_valid_d;
    logic [IDXW-1:0]   idx;

    // Round-robin search: start at last_q+1 and wrap. The first valid
    // requester found wins.
    always_comb begin : arbiter
        // NOTE: each signal gets a default before the loop. Then no path
        // leaves it unassigned, so no latch is inferred.
        any_valid_d = 1'b0;
        gnt_d       = last_q;
        idx         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDXW'((int'(last_q) + k) % NREQ);
            if (!any_valid_d && req_valid[idx]) begin
                any_valid_d = 1'b1;
                gnt_d       = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin : fsm
        if (rst) begin
            state_q <= IDLE;
            last_q  <= IDXW'(NREQ - 1);   // requester 0 wins first
            gnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments. Every
            // register then samples values from before the edge, whatever
            // order the statements are written in.
            case (state_q)
                IDLE: begin
                    if (any_valid_d) begin
                        a_q     <= req_a[int'(gnt_d) * 32 +: 32];
                        b_q     <= req_b[int'(gnt_d) * 32 +: 32];
                        op_q    <= req_op[int'(gnt_d) * OPW +: OPW];
                        gnt_q   <= gnt_d;
                        last_q  <= gnt_d;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= alu_res;
                    state_q <= RESP;
                end
                RESP: begin
                    // Only the granted requester's rsp_ready completes the response.
                    if (rsp_ready[gnt_q]) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // req_ready is a combinational function of req_valid. It is gated with
    // rst so that no accept is shown while reset is held.
    assign req_ready = (state_q == IDLE && any_valid_d && !rst)
                       ? (NREQ'(1) << gnt_d) : '0;
    assign rsp_valid = (state_q == RESP) ? (NREQ'(1) << gnt_q) : '0;
    assign rsp_res   = res_q;

    // The operand registers drive the ALU directly. They keep their last
    // values outside EXEC.
    assign alu_a  = a_q;
    assign alu_b  = b_q;
    assign alu_op = op_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arb
//   Directed bench. It runs a two-requester instance and a four-requester
//   instance, each connected to a behavioural ALU. Expected results are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_share_arb;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SLT  = 3'd5;
    localparam logic [2:0] OP_SLTU = 3'd6;
    localparam logic [2:0] OP_MUL  = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural ALU that the shared port drives.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLT:  return {31'd0, ($signed(a) < $signed(b))};
            OP_SLTU: return {31'd0, (a < b)};
            OP_MUL:  return a * b;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- two-requester instance ----------------
    logic [31:0] a2  [2];
    logic [31:0] b2  [2];
    logic [2:0]  op2 [2];
    logic [1:0]  v2, rdy2, rspv2, rspr2;
    logic [63:0] req_a2, req_b2;
    logic [5:0]  req_op2;
    logic [31:0] res2, alu_a2, alu_b2, alu_res2;
    logic [2:0]  alu_op2;

    assign req_a2   = {a2[1], a2[0]};
    assign req_b2   = {b2[1], b2[0]};
    assign req_op2  = {op2[1], op2[0]};
    assign alu_res2 = alu_model(alu_a2, alu_b2, alu_op2);

    alu_share_arb #(.NREQ(2), .OPW(3)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v2),
        .req_ready (rdy2),
        .req_a     (req_a2),
        .req_b     (req_b2),
        .req_op    (req_op2),
        .rsp_valid (rspv2),
        .rsp_ready (rspr2),
        .rsp_res   (res2),
        .alu_a     (alu_a2),
        .alu_b     (alu_b2),
        .alu_op    (alu_op2),
        .alu_res   (alu_res2)
    );

    // ---------------- four-requester instance ----------------
    logic [31:0] a4  [4];
    logic [31:0] b4  [4];
    logic [3:0]  v4, rdy4, rspv4, rspr4;
    logic [127:0] req_a4, req_b4;
    logic [11:0] req_op4;
    logic [31:0] res4, alu_a4, alu_b4, alu_res4;
    logic [2:0]  alu_op4;

    assign req_a4   = {a4[3], a4[2], a4[1], a4[0]};
    assign req_b4   = {b4[3], b4[2], b4[1], b4[0]};
    assign req_op4  = {OP_ADD, OP_ADD, OP_ADD, OP_ADD};
    assign alu_res4 = alu_model(alu_a4, alu_b4, alu_op4);

    alu_share_arb #(.NREQ(4), .OPW(3)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v4),
        .req_ready (rdy4),
        .req_a     (req_a4),
        .req_b     (req_b4),
        .req_op    (req_op4),
        .rsp_valid (rspv4),
        .rsp_ready (rspr4),
        .rsp_res   (res4),
        .alu_a     (alu_a4),
        .alu_b     (alu_b4),
        .alu_op    (alu_op4),
        .alu_res   (alu_res4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction on dut2. Call at a negedge in IDLE with the inputs already driven.
    // The task returns at a negedge in IDLE with rsp_ready released.
    task automatic txn2(input string tag, input int g, input logic [31:0] exp_res);
        #1;
        check({tag, "/req_ready"}, 32'(rdy2), 32'(1) << g);
        @(posedge clk); @(negedge clk);               // EXEC
        check({tag, "/exec_ready"}, 32'(rdy2), 32'd0);
        check({tag, "/exec_rspv"},  32'(rspv2), 32'd0);
        check({tag, "/alu_a"},      alu_a2, a2[g]);
        check({tag, "/alu_b"},      alu_b2, b2[g]);
        check({tag, "/alu_op"},     32'(alu_op2), 32'(op2[g]));
        @(posedge clk); @(negedge clk);               // RESP
        check({tag, "/rsp_valid"},  32'(rspv2), 32'(1) << g);
        check({tag, "/rsp_res"},    res2, exp_res);
        check({tag, "/resp_ready"}, 32'(rdy2), 32'd0);
        rspr2 = 2'(1 << g);
        @(posedge clk); @(negedge clk);               // back in IDLE
        rspr2 = 2'b00;
        check({tag, "/rspv_clr"},   32'(rspv2), 32'd0);
    endtask

    initial begin
        int cnt4 [4];
        logic [31:0] exp4 [4];

        exp4 = '{32'd11, 32'd22, 32'd33, 32'd44};
        cnt4 = '{0, 0, 0, 0};
        for (int i = 0; i < 2; i++) begin
            a2[i] = '0; b2[i] = '0; op2[i] = OP_ADD;
        end
        for (int i = 0; i < 4; i++) begin
            a4[i] = 32'((i + 1) * 10);
            b4[i] = 32'(i + 1);
        end
        v2 = '0; rspr2 = '0; v4 = '0; rspr4 = '0;

        // ---- reset values ----
        @(negedge clk);
        check("rst/rspv",  32'(rspv2), 32'd0);
        check("rst/res",   res2, 32'd0);
        check("rst/alu_a", alu_a2, 32'd0);
        check("rst/alu_op", 32'(alu_op2), 32'd0);
        v2 = 2'b01; a2[0] = 32'd5; b2[0] = 32'd7; op2[0] = OP_ADD;
        #1;
        check("rst/ready_held", 32'(rdy2), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---- test 1: single ADD from requester 0 ----
        txn2("t1", 0, 32'h0000000c);
        v2 = 2'b00;

        // ---- test 3: stalled response on requester 1 ----
        v2 = 2'b10; a2[1] = 32'd3; b2[1] = 32'd5; op2[1] = OP_SUB;
        #1;
        check("t3/req_ready", 32'(rdy2), 32'h2);
        @(posedge clk); @(negedge clk);               // EXEC
        v2 = 2'b01; a2[0] = 32'd99; b2[0] = 32'd1; op2[0] = OP_ADD;
        @(posedge clk); @(negedge clk);               // RESP
        for (int i = 0; i < 4; i++) begin
            check("t3/stall_rspv", 32'(rspv2), 32'h2);
            check("t3/stall_res",  res2, 32'hfffffffe);
            #1;
            check("t3/stall_ready", 32'(rdy2), 32'd0);
            rspr2 = 2'b01;                            // wrong port, must be ignored
            @(posedge clk); @(negedge clk);
        end
        check("t3/still_rspv", 32'(rspv2), 32'h2);
        rspr2 = 2'b10; v2 = 2'b00;
        @(posedge clk); @(negedge clk);
        rspr2 = 2'b00;
        check("t3/rspv_clr",  32'(rspv2), 32'd0);
        check("t3/res_hold",  res2, 32'hfffffffe);

        // ---- test 2: both requesting, grants alternate 0,1,0,1 ----
        a2[0] = 32'd10; b2[0] = 32'd3; op2[0] = OP_ADD;
        a2[1] = 32'd10; b2[1] = 32'd3; op2[1] = OP_SUB;
        v2 = 2'b11;
        txn2("t2/g0a", 0, 32'd13);
        txn2("t2/g1a", 1, 32'd7);
        txn2("t2/g0b", 0, 32'd13);
        txn2("t2/g1b", 1, 32'd7);
        v2 = 2'b00;

        // ---- test 4: MUL truncation, SLTU, SLT ----
        v2 = 2'b01; a2[0] = 32'h00010000; b2[0] = 32'h00010000; op2[0] = OP_MUL;
        txn2("t4/mul", 0, 32'h00000000);
        a2[0] = 32'hffffffff; b2[0] = 32'd1; op2[0] = OP_SLTU;
        txn2("t4/sltu", 0, 32'h00000000);
        op2[0] = OP_SLT;
        txn2("t4/slt", 0, 32'h00000001);
        v2 = 2'b00;

        // ---- test 5: reset during EXEC ----
        a2[0] = 32'd1; b2[0] = 32'd2; op2[0] = OP_ADD; v2 = 2'b01;
        #1;
        check("t5/req_ready", 32'(rdy2), 32'h1);
        @(posedge clk); @(negedge clk);               // EXEC
        v2 = 2'b00;
        check("t5/in_exec_alu_a", alu_a2, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t5/rst_rspv",  32'(rspv2), 32'd0);
        check("t5/rst_ready", 32'(rdy2), 32'd0);
        check("t5/rst_res",   res2, 32'd0);
        check("t5/rst_alu_a", alu_a2, 32'd0);
        check("t5/rst_alu_b", alu_b2, 32'd0);
        check("t5/rst_alu_op", 32'(alu_op2), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5/no_rsp", 32'(rspv2), 32'd0);
        end
        // The arbitration pointer restarts at requester 0.
        a2[0] = 32'd20; b2[0] = 32'd4; op2[0] = OP_SUB;
        a2[1] = 32'd6;  b2[1] = 32'd7; op2[1] = OP_ADD;
        v2 = 2'b11;
        txn2("t5/restart", 0, 32'h00000010);
        v2 = 2'b10;
        txn2("t5/req1", 1, 32'h0000000d);
        v2 = 2'b00;

        // ---- test 6: four requesters, 12 grants, wrong-port rsp_ready ----
        v4 = 4'hf;
        for (int n = 0; n < 12; n++) begin
            int g;
            g = n % 4;
            #1;
            check("t6/req_ready", 32'(rdy4), 32'(1) << g);
            for (int i = 0; i < 4; i++) if (rdy4[i]) cnt4[i]++;
            @(posedge clk); @(negedge clk);           // EXEC
            check("t6/exec_ready", 32'(rdy4), 32'd0);
            check("t6/alu_a", alu_a4, a4[g]);
            @(posedge clk); @(negedge clk);           // RESP
            check("t6/rsp_valid", 32'(rspv4), 32'(1) << g);
            check("t6/rsp_res",   res4, exp4[g]);
            rspr4 = ~(4'(1 << g));
            @(posedge clk); @(negedge clk);
            check("t6/wrong_port", 32'(rspv4), 32'(1) << g);
            rspr4 = 4'(1 << g);
            @(posedge clk); @(negedge clk);
            rspr4 = 4'h0;
            check("t6/rspv_clr", 32'(rspv4), 32'd0);
        end
        v4 = 4'h0;
        for (int i = 0; i < 4; i++) check("t6/grant_count", 32'(cnt4[i]), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
